// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM encoding, default sizes and
// the write-enable patterns used on the SRAM write port.
package boot_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int MAX_WORDS_DEF = 16384;

  localparam logic [3:0] WE_WORD = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words and presents each
// completed word on a registered one-cycle write strobe.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word_data,
  output logic [3:0]  word_we
);

  logic [1:0]  lane;
  logic [23:0] partial;

  assign word_done = byte_en && (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= 2'd0;
      partial   <= 24'd0;
      word_data <= 32'd0;
      word_we   <= WE_NONE;
    end else begin
      word_we <= WE_NONE;
      if (byte_en) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: partial[7:0]   <= byte_data;
          2'd1: partial[15:8]  <= byte_data;
          2'd2: partial[23:16] <= byte_data;
          default: begin
            // The fourth byte bypasses the partial buffer straight into the word.
            word_data <= {byte_data, partial};
            word_we   <= WE_WORD;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_boot_loader.sv
// Streams a length-prefixed, checksummed program image into SRAM and holds the
// CPU in reset until the image is loaded and verified.
//
//   state | meaning
//   LEN0  | waiting for low byte of word count
//   LEN1  | waiting for high byte of word count; range check
//   DATA  | receiving image bytes, writing one word per 4 bytes
//   CSUM  | waiting for trailer byte; verifies mod-256 sum
//   RUN   | image good, CPU released (terminal)
//   ERR   | image rejected (terminal)
module mem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_write,
  output logic [31:0]       mem_di,
  output logic              loading,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  boot_state_e state, state_nx;

  logic [15:0] len;
  logic [16:0] wcnt;
  logic [7:0]  csum;
  logic [7:0]  csum_nx;
  logic [15:0] n_rx;
  logic        accept;
  logic        byte_en;
  logic        word_done;

  assign accept  = in_valid && in_ready;
  assign n_rx    = {in_data, len[7:0]};
  assign csum_nx = csum + in_data;
  // in_ready is always 1 in DATA, so in_valid alone avoids a comb loop via in_ready.
  assign byte_en = in_valid && (state == ST_DATA);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LEN0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    loading  = 1'b1;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      ST_LEN0: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_LEN1;
      end
      ST_LEN1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_rx == 16'd0)              state_nx = ST_CSUM;
          else if ({1'b0, n_rx} > MAX_N)  state_nx = ST_ERR;
          else                            state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (word_done && (wcnt + 17'd1 == {1'b0, len})) state_nx = ST_CSUM;
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (csum_nx == 8'd0) ? ST_RUN : ST_ERR;
      end
      ST_RUN: begin
        loading = 1'b0;
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ST_ERR: begin
        loading = 1'b0;
        error   = 1'b1;
      end
      default: state_nx = ST_LEN0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= 16'd0;
      wcnt     <= 17'd0;
      csum     <= 8'd0;
      mem_addr <= '0;
    end else if (accept) begin
      csum <= csum_nx;
      if (state == ST_LEN0) len[7:0]  <= in_data;
      if (state == ST_LEN1) len[15:8] <= in_data;
      if (word_done) begin
        // Address is latched alongside the packed word so both are valid in the write cycle.
        mem_addr <= wcnt[ADDR_W-1:0];
        wcnt     <= wcnt + 17'd1;
      end
    end
  end

  boot_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_en   (byte_en),
    .byte_data (in_data),
    .word_done (word_done),
    .word_data (mem_di),
    .word_we   (mem_write)
  );

endmodule

// File: tb/tb_mem_boot_loader.sv
// Self-checking bench for mem_boot_loader: directed and random images checked
// against a stream-level model of the image format.
module tb_mem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [13:0] mem_addr;
  logic [3:0]  mem_write;
  logic [31:0] mem_di;
  logic        loading;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] cap_we[$];
  int          run_len = 0;
  int          wide    = 0;

  logic [31:0] exp_words[$];
  int          exp_kind;
  int          exp_nacc;
  logic [7:0]  img[$];

  mem_boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_di    (mem_di),
    .loading   (loading),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write != 4'b0000) begin
      cap_addr.push_back(32'(mem_addr));
      cap_data.push_back(mem_di);
      cap_we.push_back(32'(mem_write));
      run_len = run_len + 1;
      if (run_len > 1) wide = wide + 1;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
    cap_we.delete();
    wide = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Stream-level reference: parse length, words and checksum from the byte list.
  task automatic model(input logic [7:0] s[$]);
    int n;
    int sum;
    exp_words.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > 16384) begin
      exp_kind = 1;
      exp_nacc = 2;
      return;
    end
    exp_nacc = 3 + 4 * n;
    sum = 0;
    for (int i = 0; i < exp_nacc; i++) sum += int'(s[i]);
    for (int w = 0; w < n; w++)
      exp_words.push_back(32'(int'(s[2+4*w]) + 256 * int'(s[3+4*w])
                              + 65536 * int'(s[4+4*w]))
                          + (32'(s[5+4*w]) << 24));
    exp_kind = ((sum % 256) == 0) ? 0 : 1;
  endtask

  task automatic make_image(input int n, input bit good);
    int sum;
    logic [7:0] t;
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    sum = 0;
    foreach (img[i]) sum += int'(img[i]);
    t = 8'((256 - (sum % 256)) % 256);
    if (!good) t = 8'(int'(t) + int'($urandom_range(255, 1)));
    img.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk32({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    chk32({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk32({tag, "_mem_di"}, mem_di, 32'h0);
    chk1({tag, "_loading"}, loading, 1'b1);
    chk1({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_error"}, error, 1'b0);
  endtask

  task automatic run_image(input logic [7:0] s[$], input int gap, input bit do_rst,
                           input string tag);
    int nw;
    if (do_rst) apply_reset();
    clear_capture();
    model(s);
    for (int i = 0; i < exp_nacc - 1; i++) send(s[i], gap);
    chk1({tag, "_pre_done"}, done, 1'b0);
    chk1({tag, "_pre_cpu_rst"}, cpu_rst, 1'b1);
    chk1({tag, "_pre_in_ready"}, in_ready, 1'b1);
    send(s[exp_nacc-1], gap);
    chk1({tag, "_done"}, done, exp_kind == 0);
    chk1({tag, "_error"}, error, exp_kind == 1);
    chk1({tag, "_cpu_rst"}, cpu_rst, exp_kind != 0);
    chk1({tag, "_loading"}, loading, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk1({tag, "_in_ready_after"}, in_ready, 1'b0);
    chk32({tag, "_nwrites"}, 32'(cap_data.size()), 32'(exp_words.size()));
    nw = (cap_data.size() < exp_words.size()) ? cap_data.size() : exp_words.size();
    for (int i = 0; i < nw; i++) begin
      chk32({tag, "_addr"}, cap_addr[i], 32'(i));
      chk32({tag, "_data"}, cap_data[i], exp_words[i]);
      chk32({tag, "_we"}, cap_we[i], 32'hF);
    end
    chk32({tag, "_wide_pulses"}, 32'(wide), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    check_reset_outputs("reset");

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h48};
    run_image(img, 0, 1'b1, "two_word");
    if (cap_data.size() == 2) begin
      chk32("two_word_w0", cap_data[0], 32'h0000_0013);
      chk32("two_word_w1", cap_data[1], 32'h0010_0093);
    end else begin
      chk32("two_word_count", 32'(cap_data.size()), 32'd2);
    end

    img[10] = 8'h49;
    run_image(img, 0, 1'b1, "bad_csum");
    chk1("bad_csum_cpu_rst_hold", cpu_rst, 1'b1);
    chk1("bad_csum_error_hold", error, 1'b1);

    img = '{8'h00, 8'h00, 8'h00};
    run_image(img, 0, 1'b1, "empty");

    img = '{8'h01, 8'h40};
    run_image(img, 0, 1'b1, "oversize");

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h48};
    run_image(img, 5, 1'b1, "stall_a");
    run_image(img, 5, 1'b1, "stall_b");

    apply_reset();
    clear_capture();
    model(img);
    for (int i = 0; i < 7; i++) send(img[i], 0);
    chk32("midrst_pre_writes", 32'(cap_data.size()), 32'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check_reset_outputs("midrst");
    run_image(img, 0, 1'b0, "reload");

    for (int k = 0; k < 8; k++) begin
      make_image(int'($urandom_range(6, 1)), ($urandom_range(3, 0) != 0));
      run_image(img, int'($urandom_range(3, 0)), 1'b1, "random");
    end

    img.delete();
    begin
      int n;
      n = 16385 + int'($urandom_range(49150, 0));
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
    end
    run_image(img, 2, 1'b1, "rand_oversize");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
